axi_irq_ctrl: RTL and testbench

AXI-lite interrupt controller directly downstream of the timer and other AXI-lite peripherals. Collects their irq outputs (timer irq_out on bit 0) into per-source pending bits, with per-source enable and edge/level mode. Drives a single aggregated irq_out plus a masked vector toward the picorv32 irq input. Register-mapped on the same 12-bit AXI-lite interconnect slot format as the other peripherals.

---
 rtl/axi_irq_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi_irq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_irq_ctrl.sv
// AXI-lite interrupt controller: per-source pending/enable/trigger registers feeding irq_vec/irq_out.
// Optional macro IRQ_SYNC_EN inserts a 2-flop synchronizer on irq_in ahead of the edge/level logic.
module axi_irq_ctrl #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [31:0] RESET_TRIG = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [11:0]        s_axi_awaddr,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [31:0]        s_axi_wdata,
    input  logic [3:0]         s_axi_wstrb,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    output logic [1:0]         s_axi_bresp,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    input  logic [11:0]        s_axi_araddr,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    output logic [31:0]        s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [NUM_IRQ-1:0] irq_vec,
    output logic               irq_out
);

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    localparam logic [4:0] ADDR_PENDING = 5'h00;
    localparam logic [4:0] ADDR_ENABLE  = 5'h04;
    localparam logic [4:0] ADDR_TRIGGER = 5'h08;
    localparam logic [4:0] ADDR_ACTIVE  = 5'h0C;
    localparam logic [4:0] ADDR_HIGHEST = 5'h10;

    logic [NUM_IRQ-1:0] pending, pending_n, enable, trigger, prev, irq_s, active, w1c;
    logic [NUM_IRQ-1:0] wr_bits, wr_sel;

    wr_state_t   wr_state, wr_next;
    rd_state_t   rd_state, rd_next;
    logic        aw_have, w_have;
    logic [4:0]  aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] wr_mask;
    logic        do_write, wr_err;
    logic [31:0] rd_data_n;
    logic        rd_err;
    logic [4:0]  hi_idx;
    logic        hi_any;
    logic        unused_bits;

    function automatic logic [31:0] pad(input logic [NUM_IRQ-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_s = sync_q2;
`else
    assign irq_s = irq_in;
`endif

    assign unused_bits = ^{s_axi_awaddr[11:5], s_axi_araddr[11:5], w_data_q, wr_mask};

    assign active  = pending & enable;
    assign irq_vec = active;
    assign irq_out = |active;

    // Write channel: AW and W are captured independently, committed together once both are held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    always_comb begin
        wr_next  = wr_state;
        do_write = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (aw_have && w_have) begin
                    do_write = 1'b1;
                    wr_next  = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wr_next = W_IDLE;
                end
            end
            default: wr_next = W_IDLE;
        endcase
    end

    assign s_axi_bvalid = (wr_state == W_RESP);

    always_comb begin
        wr_err = 1'b1;
        case (aw_addr_q)
            ADDR_PENDING, ADDR_ENABLE, ADDR_TRIGGER: wr_err = 1'b0;
            default:                                 wr_err = 1'b1;
        endcase
    end

    assign wr_mask = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
    assign wr_sel  = wr_mask[NUM_IRQ-1:0];
    assign wr_bits = w_data_q[NUM_IRQ-1:0] & wr_sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            aw_have       <= 1'b0;
            w_have        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
        end else begin
            s_axi_awready <= (wr_state == W_IDLE) && s_axi_awvalid && !aw_have && !s_axi_awready;
            s_axi_wready  <= (wr_state == W_IDLE) && s_axi_wvalid && !w_have && !s_axi_wready;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_have   <= 1'b1;
                aw_addr_q <= s_axi_awaddr[4:0];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_have   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (do_write) begin
                aw_have     <= 1'b0;
                w_have      <= 1'b0;
                s_axi_bresp <= wr_err ? 2'b10 : 2'b00;
            end
        end
    end

    // Edge sources: a new rising edge beats a simultaneous W1C. Level sources simply track the input.
    always_comb begin
        w1c = '0;
        if (do_write && (aw_addr_q == ADDR_PENDING)) begin
            w1c = wr_bits;
        end
        pending_n = (trigger & ((irq_s & ~prev) | (pending & ~w1c))) | (~trigger & irq_s);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            enable  <= '0;
            trigger <= RESET_TRIG[NUM_IRQ-1:0];
            prev    <= '0;
        end else begin
            prev    <= irq_s;
            pending <= pending_n;
            if (do_write && (aw_addr_q == ADDR_ENABLE)) begin
                enable <= (enable & ~wr_sel) | wr_bits;
            end
            if (do_write && (aw_addr_q == ADDR_TRIGGER)) begin
                trigger <= (trigger & ~wr_sel) | wr_bits;
            end
        end
    end

    // Lowest-index active source wins; scanning downward leaves the lowest index last.
    always_comb begin
        hi_idx = '0;
        hi_any = |active;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                hi_idx = 5'(i);
            end
        end
    end

    always_comb begin
        rd_data_n = '0;
        rd_err    = 1'b0;
        case (s_axi_araddr[4:0])
            ADDR_PENDING: rd_data_n = pad(pending);
            ADDR_ENABLE:  rd_data_n = pad(enable);
            ADDR_TRIGGER: rd_data_n = pad(trigger);
            ADDR_ACTIVE:  rd_data_n = pad(active);
            ADDR_HIGHEST: rd_data_n = {hi_any, 26'b0, hi_idx};
            default:      rd_err    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    rd_next = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rd_next = R_IDLE;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    assign s_axi_rvalid = (rd_state == R_DATA);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_axi_arready <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= 2'b00;
        end else begin
            s_axi_arready <= (rd_state == R_IDLE) && s_axi_arvalid && !s_axi_arready;
            if (s_axi_arvalid && s_axi_arready) begin
                s_axi_rdata <= rd_data_n;
                s_axi_rresp <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_axi_irq_ctrl.sv
// Directed bench for axi_irq_ctrl with read/write-response scoreboards and immediate-assertion checks.
module tb_axi_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [11:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  irq_in = '0;
    logic [7:0]  irq_vec;
    logic        irq_out;

    int checks = 0;
    int failures = 0;

    logic [31:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic [1:0]  bq[$];

    axi_irq_ctrl #(
        .NUM_IRQ    (8),
        .RESET_TRIG (32'hA5A5_0040)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .irq_in        (irq_in),
        .irq_vec       (irq_vec),
        .irq_out       (irq_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] val);
        irq_in = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse, then wait until the pulse has had time to reach PENDING.
    task automatic pulse(input logic [7:0] val);
        applyStimulus(val);
        tick();
        applyStimulus(8'h00);
        repeat (LAT - 1) tick();
    endtask

    task automatic axi_write(input string tag, input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             input bit irq_at_commit, input logic [7:0] irq_val);
        int n;
        logic aw_hs, w_hs;
        bq.push_back(exp_resp);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (irq_at_commit) applyStimulus(irq_val);
        bready = 1'b1;
        while (!bvalid && n < 100) begin
            tick();
            n++;
        end
        checkOutput({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        checkOutput({tag, "_bresp"}, 32'(bresp), 32'(bq.pop_front()));
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [11:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        int n;
        logic hs;
        rq_data.push_back(exp_data);
        rq_resp.push_back(exp_resp);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 50) begin
            hs = arready;
            tick();
            if (hs) arvalid = 1'b0;
            n++;
        end
        arvalid = 1'b0;
        rready = 1'b1;
        while (!rvalid && n < 100) begin
            tick();
            n++;
        end
        checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        checkOutput({tag, "_rdata"}, rdata, rq_data.pop_front());
        checkOutput({tag, "_rresp"}, 32'(rresp), 32'(rq_resp.pop_front()));
        tick();
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic hs;

        resetn = 1'b0;
        repeat (2) tick();
        checkOutput("rst_ready", {awready, wready, arready}, 32'd0);
        checkOutput("rst_valid", {bvalid, rvalid}, 32'd0);
        checkOutput("rst_irq", {irq_vec, irq_out}, 32'd0);
        resetn = 1'b1;
        tick();

        axi_read("rst_pending", 12'h000, 32'h0, 2'b00);
        axi_read("rst_enable", 12'h004, 32'h0, 2'b00);
        axi_read("rst_trigger", 12'h008, 32'h0000_0040, 2'b00);
        axi_read("rst_highest", 12'h010, 32'h0, 2'b00);
        checkOutput("rst_irq_out", 32'(irq_out), 32'd0);

        // Edge source 0: latch a one-cycle pulse, then clear by W1C.
        axi_write("trig01", 12'h008, 32'h01, 4'hF, 2'b00, 0, 8'h00);
        axi_write("en01", 12'h004, 32'h01, 4'hF, 2'b00, 0, 8'h00);
        applyStimulus(8'h01);
        checkOutput("edge0_before", 32'(irq_out), 32'd0);
        tick();
        applyStimulus(8'h00);
        repeat (LAT - 1) tick();
        checkOutput("edge0_latency", 32'(irq_out), 32'd1);
        repeat (3) tick();
        checkOutput("edge0_sticky", 32'(irq_out), 32'd1);
        axi_read("edge0_highest", 12'h010, 32'h8000_0000, 2'b00);
        axi_write("w1c0", 12'h000, 32'h01, 4'hF, 2'b00, 0, 8'h00);
        checkOutput("w1c0_irq_out", 32'(irq_out), 32'd0);

        // Level source 3: W1C cannot clear while the line is high.
        axi_write("en09", 12'h004, 32'h09, 4'hF, 2'b00, 0, 8'h00);
        applyStimulus(8'h08);
        repeat (LAT) tick();
        checkOutput("lvl3_vec", 32'(irq_vec), 32'h08);
        axi_write("w1c3", 12'h000, 32'h08, 4'hF, 2'b00, 0, 8'h00);
        axi_read("lvl3_pending", 12'h000, 32'h08, 2'b00);
        applyStimulus(8'h00);
        repeat (LAT) tick();
        checkOutput("lvl3_drop", 32'(irq_out), 32'd0);

        // Sources 2 and 5 together; priority follows the enable mask.
        axi_write("trig25", 12'h008, 32'h25, 4'hF, 2'b00, 0, 8'h00);
        axi_write("en24", 12'h004, 32'h24, 4'hF, 2'b00, 0, 8'h00);
        pulse(8'h24);
        axi_read("active24", 12'h00C, 32'h24, 2'b00);
        axi_read("highest2", 12'h010, 32'h8000_0002, 2'b00);
        axi_write("en20", 12'h004, 32'h20, 4'hF, 2'b00, 0, 8'h00);
        axi_read("highest5", 12'h010, 32'h8000_0005, 2'b00);
        checkOutput("vec20", 32'(irq_vec), 32'h20);

        // Set beats clear when an edge lands in the W1C commit cycle.
        axi_write("trig27", 12'h008, 32'h27, 4'hF, 2'b00, 0, 8'h00);
        pulse(8'h02);
        axi_read("pend26", 12'h000, 32'h26, 2'b00);
        axi_write("w1c1_race", 12'h000, 32'h02, 4'hF, 2'b00, 1, 8'h02);
        applyStimulus(8'h00);
        axi_read("race_pending", 12'h000, 32'h26, 2'b00);
        axi_write("w1c_nostrb", 12'h000, 32'hFF, 4'h0, 2'b00, 0, 8'h00);
        axi_read("nostrb_pending", 12'h000, 32'h26, 2'b00);
        axi_write("w1c_all", 12'h000, 32'h26, 4'h1, 2'b00, 0, 8'h00);
        axi_read("cleared_pending", 12'h000, 32'h00, 2'b00);

        axi_write("en_hi_strb", 12'h004, 32'hFFFF_FFFF, 4'hE, 2'b00, 0, 8'h00);
        axi_read("en_hi_strb_rd", 12'h004, 32'h20, 2'b00);
        axi_write("wr_active", 12'h00C, 32'hFF, 4'hF, 2'b10, 0, 8'h00);
        axi_write("wr_highest", 12'h010, 32'hFF, 4'hF, 2'b10, 0, 8'h00);
        axi_write("wr_unmapped", 12'h018, 32'hFF, 4'hF, 2'b10, 0, 8'h00);
        axi_read("en_after_err", 12'h004, 32'h20, 2'b00);
        axi_read("rd_unmapped", 12'h01C, 32'h0, 2'b10);
        axi_write("en_all", 12'h004, 32'hFFFF_FFFF, 4'hF, 2'b00, 0, 8'h00);
        axi_read("en_all_rd", 12'h004, 32'hFF, 2'b00);

        // AW leads W by 3 cycles; bready held off 4 cycles while a second write knocks.
        bq.push_back(2'b00);
        awaddr = 12'h004; awvalid = 1'b1;
        n = 0;
        while (awvalid && n < 50) begin
            hs = awready;
            tick();
            if (hs) awvalid = 1'b0;
            n++;
        end
        awvalid = 1'b0;
        repeat (3) begin
            checkOutput("early_aw_no_bvalid", 32'(bvalid), 32'd0);
            tick();
        end
        wdata = 32'h04; wstrb = 4'hF; wvalid = 1'b1;
        while (wvalid && n < 100) begin
            hs = wready;
            tick();
            if (hs) wvalid = 1'b0;
            n++;
        end
        wvalid = 1'b0;
        while (!bvalid && n < 150) begin
            tick();
            n++;
        end
        checkOutput("late_w_bresp", 32'(bresp), 32'(bq.pop_front()));
        awaddr = 12'h004; awvalid = 1'b1; wdata = 32'hFF; wvalid = 1'b1;
        repeat (4) begin
            checkOutput("bvalid_held", 32'(bvalid), 32'd1);
            checkOutput("no_second_accept", {awready, wready}, 32'd0);
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checkOutput("bvalid_dropped", 32'(bvalid), 32'd0);
        axi_read("late_w_enable", 12'h004, 32'h04, 2'b00);

        // Reset in the middle of a write drops everything back to reset values.
        pulse(8'h04);
        checkOutput("pre_reset_irq", 32'(irq_out), 32'd1);
        awaddr = 12'h004; awvalid = 1'b1; wdata = 32'hFF; wvalid = 1'b1;
        repeat (2) tick();
        resetn = 1'b0;
        #1;
        checkOutput("midrst_outputs", {awready, wready, bvalid, irq_out}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("postrst_bvalid", 32'(bvalid), 32'd0);
        axi_read("postrst_enable", 12'h004, 32'h0, 2'b00);
        axi_read("postrst_trigger", 12'h008, 32'h40, 2'b00);
        axi_read("postrst_pending", 12'h000, 32'h0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
